// File: rtl/complex_div.sv
// rtl/complex_div.sv - sequential complex divider A = P*conj(B)/|B|^2, 18-cycle restoring division
// Optional rounding (round-half-away-from-zero) enabled by defining COMPLEX_DIV_ROUND_EN.
module complex_div (
  input  logic               clk_i,
  input  logic               srst_i,
  input  logic               valid_i,
  output logic               ready_o,
  input  logic signed [36:0] data_p_i_i,
  input  logic signed [36:0] data_p_q_i,
  input  logic signed [17:0] data_b_i_i,
  input  logic signed [17:0] data_b_q_i,
  output logic               valid_o,
  output logic        [17:0] data_i_o,
  output logic        [17:0] data_q_o,
  output logic               div0_o,
  output logic               sat_o
);

  typedef enum logic [1:0] {IDLE, CALC, DIV} state_t;

  state_t state_q, state_d;
  logic signed [36:0] p_i_q, p_i_d, p_q_q, p_q_d;
  logic signed [17:0] b_i_q, b_i_d, b_q_q, b_q_d;
  logic [55:0] rem_i_q, rem_i_d, rem_q_q, rem_q_d;
  logic [53:0] dsh_q, dsh_d;
  logic [17:0] quo_i_q, quo_i_d, quo_q_q, quo_q_d;
  logic        neg_i_q, neg_i_d, neg_q_q, neg_q_d;
  logic        ovf_i_q, ovf_i_d, ovf_q_q, ovf_q_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        valid_q, valid_d, div0_q, div0_d, sat_q, sat_d;
  logic [17:0] data_i_q, data_i_d, data_q_q, data_q_d;

  logic signed [55:0] pi_x, pq_x, bi_x, bq_x, num_i, num_q;
  logic [17:0] mag_bi, mag_bq;
  logic [35:0] den;
  logic [55:0] mag_i, mag_q, mag_i_r, mag_q_r;
  logic        ge_i, ge_q;
  logic [55:0] rem_i_n, rem_q_n;
  logic [17:0] quo_i_n, quo_q_n;
  logic [18:0] res_i, res_q;

  // Returns {saturated, two's-complement result} from magnitude and sign.
  function automatic logic [18:0] conv(input logic [17:0] q, input logic neg, input logic ovf);
    logic [18:0] r;
    if (neg) begin
      if (ovf || q > 18'd131072) r = {1'b1, 18'h20000};
      else                       r = {1'b0, -q};
    end else begin
      if (ovf || q > 18'd131071) r = {1'b1, 18'h1FFFF};
      else                       r = {1'b0, q};
    end
    return r;
  endfunction

  always_comb begin
    pi_x    = 56'(p_i_q);
    pq_x    = 56'(p_q_q);
    bi_x    = 56'(b_i_q);
    bq_x    = 56'(b_q_q);
    num_i   = pi_x * bi_x + pq_x * bq_x;
    num_q   = pq_x * bi_x - pi_x * bq_x;
    mag_bi  = b_i_q[17] ? 18'(-b_i_q) : 18'(b_i_q);
    mag_bq  = b_q_q[17] ? 18'(-b_q_q) : 18'(b_q_q);
    den     = 36'(mag_bi) * 36'(mag_bi) + 36'(mag_bq) * 36'(mag_bq);
    mag_i   = num_i[55] ? 56'(-num_i) : 56'(num_i);
    mag_q   = num_q[55] ? 56'(-num_q) : 56'(num_q);
`ifdef COMPLEX_DIV_ROUND_EN
    mag_i_r = mag_i + {21'b0, den[35:1]};
    mag_q_r = mag_q + {21'b0, den[35:1]};
`else
    mag_i_r = mag_i;
    mag_q_r = mag_q;
`endif
    // Divisor is pre-shifted by 17 and walks right, so each step is one compare/subtract.
    ge_i    = rem_i_q >= {2'b0, dsh_q};
    ge_q    = rem_q_q >= {2'b0, dsh_q};
    rem_i_n = ge_i ? rem_i_q - {2'b0, dsh_q} : rem_i_q;
    rem_q_n = ge_q ? rem_q_q - {2'b0, dsh_q} : rem_q_q;
    quo_i_n = {quo_i_q[16:0], ge_i};
    quo_q_n = {quo_q_q[16:0], ge_q};
    res_i   = conv(quo_i_n, neg_i_q, ovf_i_q);
    res_q   = conv(quo_q_n, neg_q_q, ovf_q_q);
  end

  always_comb begin
    state_d  = state_q;
    p_i_d    = p_i_q;
    p_q_d    = p_q_q;
    b_i_d    = b_i_q;
    b_q_d    = b_q_q;
    rem_i_d  = rem_i_q;
    rem_q_d  = rem_q_q;
    dsh_d    = dsh_q;
    quo_i_d  = quo_i_q;
    quo_q_d  = quo_q_q;
    neg_i_d  = neg_i_q;
    neg_q_d  = neg_q_q;
    ovf_i_d  = ovf_i_q;
    ovf_q_d  = ovf_q_q;
    cnt_d    = cnt_q;
    valid_d  = 1'b0;
    div0_d   = div0_q;
    sat_d    = sat_q;
    data_i_d = data_i_q;
    data_q_d = data_q_q;
    case (state_q)
      IDLE: begin
        if (valid_i) begin
          p_i_d   = data_p_i_i;
          p_q_d   = data_p_q_i;
          b_i_d   = data_b_i_i;
          b_q_d   = data_b_q_i;
          state_d = CALC;
        end
      end
      CALC: begin
        if (den == 36'd0) begin
          data_i_d = '0;
          data_q_d = '0;
          div0_d   = 1'b1;
          sat_d    = 1'b0;
          valid_d  = 1'b1;
          state_d  = IDLE;
        end else begin
          neg_i_d = num_i[55];
          neg_q_d = num_q[55];
          rem_i_d = mag_i_r;
          rem_q_d = mag_q_r;
          ovf_i_d = mag_i_r >= {2'b0, den, 18'b0};
          ovf_q_d = mag_q_r >= {2'b0, den, 18'b0};
          dsh_d   = {1'b0, den, 17'b0};
          quo_i_d = '0;
          quo_q_d = '0;
          cnt_d   = 5'd17;
          state_d = DIV;
        end
      end
      DIV: begin
        rem_i_d = rem_i_n;
        rem_q_d = rem_q_n;
        quo_i_d = quo_i_n;
        quo_q_d = quo_q_n;
        dsh_d   = dsh_q >> 1;
        cnt_d   = cnt_q - 5'd1;
        if (cnt_q == 5'd0) begin
          data_i_d = res_i[17:0];
          data_q_d = res_q[17:0];
          sat_d    = res_i[18] | res_q[18];
          div0_d   = 1'b0;
          valid_d  = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge srst_i) begin
    if (srst_i) begin
      state_q  <= IDLE;
      p_i_q    <= '0;
      p_q_q    <= '0;
      b_i_q    <= '0;
      b_q_q    <= '0;
      rem_i_q  <= '0;
      rem_q_q  <= '0;
      dsh_q    <= '0;
      quo_i_q  <= '0;
      quo_q_q  <= '0;
      neg_i_q  <= 1'b0;
      neg_q_q  <= 1'b0;
      ovf_i_q  <= 1'b0;
      ovf_q_q  <= 1'b0;
      cnt_q    <= '0;
      valid_q  <= 1'b0;
      div0_q   <= 1'b0;
      sat_q    <= 1'b0;
      data_i_q <= '0;
      data_q_q <= '0;
    end else begin
      state_q  <= state_d;
      p_i_q    <= p_i_d;
      p_q_q    <= p_q_d;
      b_i_q    <= b_i_d;
      b_q_q    <= b_q_d;
      rem_i_q  <= rem_i_d;
      rem_q_q  <= rem_q_d;
      dsh_q    <= dsh_d;
      quo_i_q  <= quo_i_d;
      quo_q_q  <= quo_q_d;
      neg_i_q  <= neg_i_d;
      neg_q_q  <= neg_q_d;
      ovf_i_q  <= ovf_i_d;
      ovf_q_q  <= ovf_q_d;
      cnt_q    <= cnt_d;
      valid_q  <= valid_d;
      div0_q   <= div0_d;
      sat_q    <= sat_d;
      data_i_q <= data_i_d;
      data_q_q <= data_q_d;
    end
  end

  assign ready_o  = (state_q == IDLE);
  assign valid_o  = valid_q;
  assign data_i_o = data_i_q;
  assign data_q_o = data_q_q;
  assign div0_o   = div0_q;
  assign sat_o    = sat_q;

endmodule

// File: tb/tb_complex_div.sv
// tb/tb_complex_div.sv - scoreboard bench for complex_div against an arithmetic reference model
module tb_complex_div;
  logic               clk = 1'b0;
  logic               srst_i = 1'b1;
  logic               valid_i = 1'b0;
  logic               ready_o;
  logic signed [36:0] p_i = '0, p_q = '0;
  logic signed [17:0] b_i = '0, b_q = '0;
  logic               valid_o;
  logic        [17:0] data_i_o, data_q_o;
  logic               div0_o, sat_o;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct {
    longint di;
    longint dq;
    bit     div0;
    bit     sat;
    int     lat;
    int     acc;
  } exp_t;
  exp_t sb[$];

  complex_div dut (
    .clk_i(clk), .srst_i(srst_i), .valid_i(valid_i), .ready_o(ready_o),
    .data_p_i_i(p_i), .data_p_q_i(p_q), .data_b_i_i(b_i), .data_b_q_i(b_q),
    .valid_o(valid_o), .data_i_o(data_i_o), .data_q_o(data_q_o),
    .div0_o(div0_o), .sat_o(sat_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic longint quot(input longint n, input longint d, output bit s);
    longint mag, q;
    mag = (n < 0) ? -n : n;
`ifdef COMPLEX_DIV_ROUND_EN
    mag = mag + d / 2;
`endif
    q = mag / d;
    s = 1'b0;
    if (n < 0) begin
      if (q > 131072) begin s = 1'b1; return -131072; end
      return -q;
    end
    if (q > 131071) begin s = 1'b1; return 131071; end
    return q;
  endfunction

  function automatic exp_t model(input longint pi, input longint pq, input longint bi, input longint bq);
    exp_t e;
    longint ni, nq, den;
    bit si, sq;
    ni  = pi * bi + pq * bq;
    nq  = pq * bi - pi * bq;
    den = bi * bi + bq * bq;
    if (den == 0) begin
      e.di = 0; e.dq = 0; e.div0 = 1'b1; e.sat = 1'b0; e.lat = 1;
    end else begin
      e.di = quot(ni, den, si);
      e.dq = quot(nq, den, sq);
      e.div0 = 1'b0; e.sat = si | sq; e.lat = 19;
    end
    return e;
  endfunction

  // Accept watcher: samples pre-edge values, so ready_o is the state before this edge.
  always @(posedge clk) begin
    exp_t e;
    cyc++;
    if (!srst_i && valid_i && ready_o) begin
      e = model(longint'(p_i), longint'(p_q), longint'(b_i), longint'(b_q));
      e.acc = cyc;
      sb.push_back(e);
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (valid_o) begin
      if (sb.size() == 0) begin
        chk("unexpected_valid", 1, 0);
      end else begin
        e = sb.pop_front();
        chk("data_i", longint'($signed(data_i_o)), e.di);
        chk("data_q", longint'($signed(data_q_o)), e.dq);
        chk("div0", longint'(div0_o), longint'(e.div0));
        chk("sat", longint'(sat_o), longint'(e.sat));
        chk("latency", longint'(cyc - e.acc), longint'(e.lat));
      end
    end
  end

  task automatic send(input longint pi, input longint pq, input longint bi, input longint bq);
    int n = 0;
    while (!ready_o && n < 100) begin @(posedge clk); #1; n++; end
    if (!ready_o) chk("ready_timeout", 0, 1);
    p_i = pi[36:0]; p_q = pq[36:0]; b_i = bi[17:0]; b_q = bq[17:0];
    valid_i = 1'b1;
    @(posedge clk); #1;
    valid_i = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin @(posedge clk); #1; n++; end
    if (sb.size() != 0) chk("drain_timeout", longint'(sb.size()), 0);
  endtask

  function automatic longint rnd18();
    logic [17:0] v;
    v = 18'($urandom());
    return longint'($signed(v));
  endfunction

  function automatic longint rnd37();
    logic [36:0] v;
    v = 37'({$urandom(), $urandom()});
    return longint'($signed(v));
  endfunction

  task automatic check_idle_zero(input string tag);
    chk({tag, "_ready"}, longint'(ready_o), 1);
    chk({tag, "_valid"}, longint'(valid_o), 0);
    chk({tag, "_data_i"}, longint'(data_i_o), 0);
    chk({tag, "_data_q"}, longint'(data_q_o), 0);
    chk({tag, "_div0"}, longint'(div0_o), 0);
    chk({tag, "_sat"}, longint'(sat_o), 0);
  endtask

  initial begin
    longint ai, aq, bi, bq;
    repeat (2) @(posedge clk);
    #1;
    check_idle_zero("reset");
    srst_i = 1'b0;
    @(posedge clk); #1;

    send(23, 14, 5, -2);
    send(-131072, 131071, 1, 0);
    valid_i = 1'b1;
    for (int i = 0; i < 17; i++) begin
      p_i = 37'(rnd37()); p_q = 37'(rnd37()); b_i = 18'(rnd18()); b_q = 18'(rnd18());
      @(posedge clk); #1;
    end
    valid_i = 1'b0;
    send(-131072, 131071, 1, 0);
    send(5, 5, 0, 0);
    send(7, 0, 2, 0);
    send(-7, 0, 2, 0);
    send(longint'(1) << 35, -(longint'(1) << 35), 1, 0);

    for (int k = 0; k < 40; k++) begin
      bi = (k % 10 == 9) ? longint'($urandom_range(6)) - 3 : rnd18();
      bq = (k % 10 == 9) ? longint'($urandom_range(6)) - 3 : rnd18();
      if (k % 3 == 0) begin
        send(rnd37(), rnd37(), bi, bq);
      end else begin
        ai = rnd18(); aq = rnd18();
        send(ai * bi - aq * bq, ai * bq + aq * bi, bi, bq);
      end
    end
    drain();

    send(23, 14, 5, -2);
    repeat (10) @(posedge clk);
    #1;
    srst_i = 1'b1;
    sb.delete();
    #1;
    check_idle_zero("midreset");
    @(posedge clk); #1;
    srst_i = 1'b0;
    @(posedge clk); #1;
    chk("post_reset_ready", longint'(ready_o), 1);
    repeat (25) @(posedge clk);
    #1;
    send(23, 14, 5, -2);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/complex_div.md
# complex_div

Sequential complex divider that recovers the 18-bit I/Q operand of a complex product. Given a 37-bit complex product P and an 18-bit complex divisor B, it computes A = P / B = P·conj(B) / |B|². It is the inverse datapath of the team's registered complex multiplier and accepts that block's output widths unchanged. It uses a valid/ready input handshake, an 18-cycle shared restoring division for I and Q, and a one-cycle output pulse.

## Interface
- No parameters. Widths are fixed: product 37 bits, operands and results 18 bits.
- clk_i  in  1  single clock, rising edge
- srst_i  in  1  reset, asynchronous, active-high; clears all state and outputs
- valid_i  in  1  input sample valid
- ready_o  out  1  block idle and able to accept
- data_p_i_i  in  37  signed product, real part
- data_p_q_i  in  37  signed product, imaginary part
- data_b_i_i  in  18  signed divisor, real part
- data_b_q_i  in  18  signed divisor, imaginary part
- valid_o  out  1  one-cycle result strobe
- data_i_o  out  18  signed quotient, real part
- data_q_o  out  18  signed quotient, imaginary part
- div0_o  out  1  divisor was 0+0j; qualified by valid_o
- sat_o  out  1  I or Q result saturated; qualified by valid_o

## Operation
- States: IDLE, CALC, DIV.
- ready_o = 1 only in IDLE. An accept occurs when valid_i && ready_o. On accept, all four inputs are registered and the FSM moves to CALC. In any other state valid_i is ignored.
- CALC (one cycle) registers:
  - num_i = p_i·b_i + p_q·b_q (56-bit signed)
  - num_q = p_q·b_i − p_i·b_q (56-bit signed)
  - den = b_i² + b_q² (36-bit unsigned)
  - sign flags and magnitudes |num_i| and |num_q|
- If den == 0: load data_i_o = data_q_o = 0, div0_o = 1, sat_o = 0, pulse valid_o, and go to IDLE.
- Otherwise, precheck overflow per component: |num| ≥ den·2^18 marks that component as overflowed. Load the 5-bit counter with 17 and go to DIV.
- DIV runs a restoring division, one quotient bit per cycle, MSB first. I and Q run in parallel against the same den. 18 iterations produce an 18-bit magnitude q.
- Final conversion per component:
  - If overflowed, or the positive result has q > 131071, or the negative result has q > 131072: saturate to 131071 / −131072 (following the sign) and set sat_o.
  - Otherwise output ±q.
- Rounding defaults to truncation toward zero.
- After the last iteration: load outputs, pulse valid_o, and go to IDLE.

## Timing
- Reset values: state IDLE, ready_o = 1, valid_o = 0, data_i_o = data_q_o = 0, div0_o = 0, sat_o = 0, all internal registers 0.
- Let E0 be the accept edge.
  - E1: CALC completes.
  - E2..E19: 18 DIV iterations.
  - At E19: outputs load and valid_o = 1 for exactly the cycle E19→E20.
  - Latency is 19 cycles. ready_o returns high after E19.
- A new accept is allowed in the same cycle that valid_o is high. Sustained throughput is one result per 19 cycles.
- Divide-by-zero path: valid_o is high in the cycle E1→E2, so latency is 1 cycle.
- data_i_o, data_q_o, div0_o and sat_o hold their values until the next result load. They are not cleared when valid_o drops.
- valid_o never stays high more than one cycle. There is no output back-pressure; the consumer must accept on the strobe.
- Reset asserted mid-operation aborts immediately. No valid_o is produced for the aborted sample, and the block returns to IDLE/ready on the first edge after reset deasserts.

## Configuration
- COMPLEX_DIV_ROUND_EN defined:
  - In CALC, add floor(den/2) to each magnitude before division. This gives round-half-away-from-zero.
  - Apply the overflow precheck to the rounded magnitude.
  - Latency is unchanged.
- COMPLEX_DIV_ROUND_EN undefined: truncation toward zero, no adder in the path.

## Test plan
- P = (23, 14), B = (5, −2) → 19 cycles after accept: valid_o = 1, out = (3, 4), div0_o = 0, sat_o = 0.
- P = (−131072, 131071), B = (1, 0) → out = (−131072, 131071), sat_o = 0. Repeat back-to-back, asserting valid_i while busy → extra samples ignored, exactly one result per accept.
- B = (0, 0), any P → valid_o 1 cycle after accept, out = (0, 0), div0_o = 1.
- P = (7, 0), B = (2, 0) (num = 14, den = 4):
  - Without the macro → out = (3, 0). With COMPLEX_DIV_ROUND_EN → (4, 0).
  - P = (−7, 0) → (−3, 0) without the macro, (−4, 0) with it.
- P = (2^35, −2^35), B = (1, 0) → out = (131071, −131072), sat_o = 1.
- Assert srst_i at cycle 10 of a division → no valid_o, outputs 0, ready_o = 1. A subsequent P = (23, 14), B = (5, −2) yields (3, 4).
